// File: rtl/cardinal_nic.sv
// cardinal_nic: joins one processing element to the PE port of a cardinal ring router.
// It has a one-entry eject buffer that the processor reads and a one-entry inject buffer that only sends on a matching VC polarity.
module cardinal_nic (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic [63:0] d_in,
    output logic [63:0] d_out,
    input  logic        nicEn,
    input  logic        nicEnWr,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [63:0] net_di,
    output logic        net_so,
    input  logic        net_ro,
    output logic [63:0] net_do,
    input  logic        net_polarity
);

    logic [63:0] in_buf;
    logic        in_full;
    logic [63:0] out_buf;
    logic        out_full;
    logic [7:0]  rx_cnt;
    logic [7:0]  tx_cnt;

    logic rd_en;
    logic wr_en;
    logic eject;
    logic inject;

    assign rd_en  = nicEn & ~nicEnWr;
    assign wr_en  = nicEn & nicEnWr;
    assign net_ri = ~in_full;
    assign net_so = out_full & (out_buf[63] == net_polarity);
    assign net_do = out_full ? out_buf : '0;
    assign eject  = net_si & net_ri;
    assign inject = net_so & net_ro;

    always_comb begin
        d_out = '0;
        if (rd_en) begin
            case (addr)
                2'b00:   d_out = in_buf;
                2'b01:   d_out = {48'b0, rx_cnt, 7'b0, in_full};
                2'b11:   d_out = {48'b0, tx_cnt, 7'b0, out_full};
                default: d_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_buf   <= '0;
            in_full  <= 1'b0;
            out_buf  <= '0;
            out_full <= 1'b0;
            rx_cnt   <= '0;
            tx_cnt   <= '0;
        end else begin
            // An ejection and a read that drains the buffer cannot coincide, because net_ri is low while the buffer is full.
            if (eject) begin
                in_buf  <= net_di;
                in_full <= 1'b1;
                rx_cnt  <= rx_cnt + 8'd1;
            end else if (rd_en && addr == 2'b00 && in_full) begin
                in_full <= 1'b0;
            end

            // A write that lands on the draining edge still sees out_full=1, so it is dropped.
            if (inject) begin
                out_full <= 1'b0;
                tx_cnt   <= tx_cnt + 8'd1;
            end else if (wr_en && addr == 2'b10 && !out_full) begin
                out_buf  <= d_in;
                out_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// Scoreboard bench for cardinal_nic: stimulus queues expected packets and read data,
// and a negedge monitor pops and compares them when the DUT transfers or is read.
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicEnWr;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_tx[$];
    logic [63:0] exp_rd[$];

    cardinal_nic dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicEnWr(nicEnWr), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: compare every transfer and every processor read against the scoreboard.
    always @(negedge clk) begin
        if (net_so === 1'b1 && net_ro === 1'b1) begin
            if (exp_tx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx: got %h expected no transfer", net_do);
            end else begin
                check("tx_data", net_do, exp_tx.pop_front());
            end
        end
        if (nicEn === 1'b1 && nicEnWr === 1'b0) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd: got %h expected no read", d_out);
            end else begin
                check("rd_data", d_out, exp_rd.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [63:0] exp);
        nicEn = 1'b1; nicEnWr = 1'b0; addr = a;
        exp_rd.push_back(exp);
        tick();
        nicEn = 1'b0;
    endtask

    task automatic wr(input logic [63:0] d);
        nicEn = 1'b1; nicEnWr = 1'b1; addr = 2'b10; d_in = d;
        tick();
        nicEn = 1'b0; nicEnWr = 1'b0;
    endtask

    task automatic eject_one(input logic [63:0] d);
        net_si = 1'b1; net_di = d;
        tick();
        net_si = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addr = '0; d_in = '0; nicEn = 1'b0; nicEnWr = 1'b0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        #2;
        check("rst_d_out", d_out, 64'h0);
        check("rst_net_so", {63'b0, net_so}, 64'h0);
        check("rst_net_do", net_do, 64'h0);
        check("rst_net_ri", {63'b0, net_ri}, 64'h1);
        tick();
        reset = 1'b0;
        tick();
        rd(2'b01, 64'h0);
        rd(2'b11, 64'h0);

        // Odd-VC packet only leaves when polarity is 1.
        net_ro = 1'b1; net_polarity = 1'b1;
        exp_tx.push_back(64'h8000_0000_0000_00AA);
        wr(64'h8000_0000_0000_00AA);
        net_polarity = 1'b0; #1;
        check("pol0_net_so", {63'b0, net_so}, 64'h0);
        check("pol0_net_do", net_do, 64'h8000_0000_0000_00AA);
        tick(); net_polarity = 1'b1; #1;
        check("pol1_net_so", {63'b0, net_so}, 64'h1);
        tick(); net_polarity = 1'b0; #1;
        check("after_tx_so", {63'b0, net_so}, 64'h0);
        tick(); net_polarity = 1'b1; #1;
        check("after_tx_do", net_do, 64'h0);
        tick();
        rd(2'b11, 64'h100);

        // Backpressure: second write into a full buffer is lost.
        net_ro = 1'b0; net_polarity = 1'b0;
        exp_tx.push_back(64'h1);
        wr(64'h1);
        wr(64'h2);
        check("bp_net_do", net_do, 64'h1);
        check("bp_net_so", {63'b0, net_so}, 64'h1);
        rd(2'b11, 64'h101);
        rd(2'b10, 64'h0);
        net_polarity = 1'b1; net_ro = 1'b1; #1;
        check("bp_odd_so", {63'b0, net_so}, 64'h0);
        tick(); net_polarity = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); net_polarity = ~net_polarity;
        end
        rd(2'b11, 64'h200);

        // Write on the same edge the buffer drains is dropped.
        net_ro = 1'b0; net_polarity = 1'b0;
        exp_tx.push_back(64'h5);
        wr(64'h5);
        net_ro = 1'b1;
        wr(64'h6);
        for (int i = 0; i < 3; i++) begin
            tick(); net_polarity = ~net_polarity;
        end
        net_ro = 1'b0;
        rd(2'b11, 64'h300);

        // Ejection and processor read.
        eject_one(64'hDEAD_BEEF_0000_0001);
        check("ej_net_ri_low", {63'b0, net_ri}, 64'h0);
        rd(2'b01, 64'h101);
        rd(2'b00, 64'hDEAD_BEEF_0000_0001);
        check("ej_net_ri_high", {63'b0, net_ri}, 64'h1);
        rd(2'b01, 64'h100);
        rd(2'b00, 64'hDEAD_BEEF_0000_0001);
        rd(2'b01, 64'h100);

        // 255 more packets bring rx_cnt from 1 around to 0.
        for (int i = 0; i < 255; i++) begin
            eject_one(64'(i) << 4);
            rd(2'b00, 64'(i) << 4);
        end
        rd(2'b01, 64'h0);

        // Asynchronous reset with both buffers full.
        net_polarity = 1'b0;
        wr(64'h7);
        eject_one(64'h9);
        check("pre_rst_so", {63'b0, net_so}, 64'h1);
        check("pre_rst_ri", {63'b0, net_ri}, 64'h0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_so", {63'b0, net_so}, 64'h0);
        check("mid_rst_do", net_do, 64'h0);
        check("mid_rst_ri", {63'b0, net_ri}, 64'h1);
        #1 reset = 1'b0;
        tick();
        rd(2'b01, 64'h0);
        rd(2'b11, 64'h0);

        tick(); tick();
        check("tx_queue_empty", 64'(exp_tx.size()), 64'h0);
        check("rd_queue_empty", 64'(exp_rd.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
